// File: rtl/stream_arb2.sv
// Two-source packet-level round-robin arbiter with a single registered output stage.
// A source keeps the grant from its first beat until its last beat is accepted.
module stream_arb2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [WIDTH-1:0] s0_data,
  input  logic             s0_last,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [WIDTH-1:0] s1_data,
  input  logic             s1_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             m_src
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             m_src_q, m_src_d;

  logic             grant_vld;
  logic             grant_idx;
  logic             load;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             accept;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_src_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_src_q   <= m_src_d;
    end
  end

  // Output process: grant selection and source handshakes
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    case (state_q)
      LOCK0: begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end
      LOCK1: begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
      default: begin
        if (s0_valid && s1_valid) begin
          grant_vld = 1'b1;
          grant_idx = ptr_q;
        end else if (s0_valid) begin
          grant_vld = 1'b1;
          grant_idx = 1'b0;
        end else if (s1_valid) begin
          grant_vld = 1'b1;
          grant_idx = 1'b1;
        end
      end
    endcase

    load = !m_valid_q || m_ready;

    // A locked source keeps ready even while its valid is low, so the other side stays blocked.
    s0_ready = !rst && grant_vld && !grant_idx && load;
    s1_ready = !rst && grant_vld &&  grant_idx && load;

    sel_valid = grant_idx ? s1_valid : s0_valid;
    sel_data  = grant_idx ? s1_data  : s0_data;
    sel_last  = grant_idx ? s1_last  : s0_last;
    accept    = (s0_ready && s0_valid) || (s1_ready && s1_valid);
  end

  // Next-state process: lock tracking, priority pointer and output stage
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_src_d   = m_src_q;

    case (state_q)
      IDLE: begin
        if (accept && !sel_last) begin
          state_d = grant_idx ? LOCK1 : LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        if (accept && sel_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept && sel_last) begin
      ptr_d = !grant_idx;
    end

    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = sel_data;
      m_last_d  = sel_last;
      m_src_d   = grant_idx;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_src   = m_src_q;

endmodule

// File: tb/tb_stream_arb2.sv
// Bench for stream_arb2: table of per-cycle vectors with expected handshakes,
// plus a scoreboard of expected output beats popped on each downstream handshake.
module tb_stream_arb2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s0_valid = 1'b0, s0_last = 1'b0;
  logic       s1_valid = 1'b0, s1_last = 1'b0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_ready, s1_ready;
  logic       m_valid, m_last, m_src;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;

  stream_arb2 #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_last(s0_last),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_last(s1_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_src(m_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s0v;
    logic [7:0] s0d;
    logic       s0l;
    logic       s1v;
    logic [7:0] s1d;
    logic       s1l;
    logic       mr;
    logic       e0r;
    logic       e1r;
    logic       emv;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       s;
  } beat_t;

  vec_t  tbl[64];
  int    n_rows = 0;
  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;

  function void add(input logic s0v, input logic [7:0] s0d, input logic s0l,
                    input logic s1v, input logic [7:0] s1d, input logic s1l,
                    input logic mr, input logic e0r, input logic e1r, input logic emv);
    tbl[n_rows] = '{s0v, s0d, s0l, s1v, s1d, s1l, mr, e0r, e1r, emv};
    n_rows++;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check handshakes, push expected beat, clock, check valid.
  task automatic apply(input int idx);
    vec_t  v;
    beat_t b;
    v = tbl[idx];
    s0_valid = v.s0v; s0_data = v.s0d; s0_last = v.s0l;
    s1_valid = v.s1v; s1_data = v.s1d; s1_last = v.s1l;
    m_ready  = v.mr;
    #1;
    chk($sformatf("row%0d s0_ready", idx), {31'd0, s0_ready}, {31'd0, v.e0r});
    chk($sformatf("row%0d s1_ready", idx), {31'd0, s1_ready}, {31'd0, v.e1r});
    if (v.e0r && v.s0v) begin
      b = '{v.s0d, v.s0l, 1'b0};
      sb.push_back(b);
    end
    if (v.e1r && v.s1v) begin
      b = '{v.s1d, v.s1l, 1'b1};
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    chk($sformatf("row%0d m_valid", idx), {31'd0, m_valid}, {31'd0, v.emv});
    $display("row %0d: s0r=%0b s1r=%0b m_valid=%0b m_data=%02h m_src=%0b",
             idx, v.e0r, v.e1r, m_valid, m_data, m_src);
  endtask

  // Output monitor: inputs are stable from just after one edge to the next, so the
  // falling-edge sample equals the values seen at the following handshake edge.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected beat: got %02h expected none", m_data);
      end else begin
        e = sb.pop_front();
        chk("beat data", {24'd0, m_data}, {24'd0, e.d});
        chk("beat last", {31'd0, m_last}, {31'd0, e.l});
        chk("beat src",  {31'd0, m_src},  {31'd0, e.s});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " m_valid"},  {31'd0, m_valid},  32'd0);
    chk({tag, " m_data"},   {24'd0, m_data},   32'd0);
    chk({tag, " m_last"},   {31'd0, m_last},   32'd0);
    chk({tag, " m_src"},    {31'd0, m_src},    32'd0);
    chk({tag, " s0_ready"}, {31'd0, s0_ready}, 32'd0);
    chk({tag, " s1_ready"}, {31'd0, s1_ready}, 32'd0);
  endtask

  int mark_e;

  initial begin
    // Alternating single-beat packets from both sources
    for (int i = 0; i < 2; i++) begin
      add(1, 8'h11, 1, 1, 8'h22, 1, 1, 1, 0, 1);
      add(1, 8'h11, 1, 1, 8'h22, 1, 1, 0, 1, 1);
    end
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    // Three-beat packet from s0 holds off s1
    add(1, 8'hA0, 0, 1, 8'hB0, 1, 1, 1, 0, 1);
    add(1, 8'hA1, 0, 1, 8'hB0, 1, 1, 1, 0, 1);
    add(1, 8'hA2, 1, 1, 8'hB0, 1, 1, 1, 0, 1);
    add(0, 8'h00, 0, 1, 8'hB0, 1, 1, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    // Downstream stall with 0x5C held, then no-bubble resume
    add(1, 8'h5C, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 8'h5D, 1, 1, 8'h6E, 1, 0, 0, 0, 1);
    add(1, 8'h5D, 1, 1, 8'h6E, 1, 1, 0, 1, 1);
    add(1, 8'h5D, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    // s1 locked, drops valid for 3 cycles while s0 waits
    add(1, 8'hD0, 1, 1, 8'hC0, 0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 8'hD0, 1, 0, 8'h00, 0, 1, 0, 1, 0);
    add(1, 8'hD0, 1, 1, 8'hC1, 1, 1, 0, 1, 1);
    add(1, 8'hD0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    // Enter LOCK0 with a stalled beat; reset follows by hand
    add(1, 8'hE0, 0, 0, 8'h00, 0, 0, 1, 0, 1);
    mark_e = n_rows;
    // After reset: source 0 wins first
    add(1, 8'hF0, 1, 1, 8'hF1, 1, 1, 1, 0, 1);
    add(1, 8'hF0, 1, 1, 8'hF1, 1, 1, 0, 1, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);
    // Single-source streaming
    for (int i = 1; i <= 8; i++) add(1, 8'(i), 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0);

    // Reset with both sources presenting data
    s0_valid = 1'b1; s1_valid = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < mark_e; i++) apply(i);

    // Asynchronous reset in LOCK0 with a buffered beat
    s0_valid = 1'b1; s0_data = 8'hE1; s1_valid = 1'b1; s1_data = 8'hE2; m_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async reset");
    $display("async reset: m_valid=%0b m_src=%0b", m_valid, m_src);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = mark_e; i < n_rows; i++) apply(i);

    repeat (2) @(posedge clk);
    chk("scoreboard empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
